// File: rtl/fp32_div_seq_pkg.sv
// Shared types and constants for the sequential FP32 divider.
package fp_div_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  typedef struct packed {
    logic invalid;
    logic dz;
    logic ovf;
    logic unf;
  } flags_t;

  typedef enum logic [1:0] {ZERO, NORM_NUM, INF, NAN} cls_t;

  // Which result the NORM cycle emits: the computed quotient or a fixed special value.
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF_DZ, SP_INF, SP_ZERO} sel_t;

endpackage

// File: rtl/fp32_div_seq_if.sv
// Start/done handshake bundle between the FP unit and the divider.
interface fp32_div_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (output start, a, b, input busy, done, result, flags);
  modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp32_div_seq_classify.sv
// Operand classification and special-result selection for a / b.
// Inputs exclude the sign bit; denormals are classed as zero.
module fp_div_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] a_i,
  input  logic [EXP_W+MAN_W-1:0] b_i,
  output cls_t                   cls_a_o,
  output cls_t                   cls_b_o,
  output sel_t                   sel_o
);

  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)              return ZERO;
    else if (e != '1)         return NORM_NUM;
    else if (m == '0)         return INF;
    else                      return NAN;
  endfunction

  // Classify each operand, then pick the special result by IEEE priority.
  always_comb begin
    cls_a_o = classify(a_i[EXP_W+MAN_W-1:MAN_W], a_i[MAN_W-1:0]);
    cls_b_o = classify(b_i[EXP_W+MAN_W-1:MAN_W], b_i[MAN_W-1:0]);
    sel_o   = SP_NONE;
    if (cls_a_o == NAN || cls_b_o == NAN ||
        (cls_a_o == ZERO && cls_b_o == ZERO) ||
        (cls_a_o == INF  && cls_b_o == INF))
      sel_o = SP_NAN;
    else if (cls_a_o == INF)
      sel_o = SP_INF;
    else if (cls_b_o == ZERO)
      sel_o = SP_INF_DZ;
    else if (cls_a_o == ZERO || cls_b_o == INF)
      sel_o = SP_ZERO;
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 divider: restoring shift-subtract, one quotient bit per cycle.
// Optional macro FP_DIV_RNE_EN: round-to-nearest-even; otherwise truncate.
module fp32_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic           clk,
  input logic           rst,
  fp32_div_seq_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NITER = MAN_W + 3;
  localparam int EW    = EXP_W + 2;
  localparam int RW    = MAN_W + 2;
  localparam int CW    = $clog2(NITER);
  localparam int BIAS_L = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  function automatic logic round_inc(input logic g, input logic s, input logic lsb);
    return RNE & g & (s | lsb);
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [RW-1:0]       r_q;
  logic [MAN_W:0]      d_q;
  logic [NITER-1:0]    q_q;
  logic signed [EW-1:0] e_q;
  logic                s_q;
  sel_t                sel_q;
  logic                busy_q, done_q;
  logic [W-1:0]        result_q, res_d;
  flags_t              flags_q, flg_d;

  cls_t cls_a, cls_b;
  sel_t sel;

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
    .a_i     (bus.a[W-2:0]),
    .b_i     (bus.b[W-2:0]),
    .cls_a_o (cls_a),
    .cls_b_o (cls_b),
    .sel_o   (sel)
  );

  logic                 load;
  logic                 special;
  logic signed [EW-1:0] e_load;
  logic                 qbit;
  logic [RW-2:0]        r_rem;

  assign load    = (state_q == IDLE) && bus.start;
  assign special = (cls_a != NORM_NUM) || (cls_b != NORM_NUM);
  assign e_load  = EW'({2'b00, bus.a[W-2:MAN_W]}) - EW'({2'b00, bus.b[W-2:MAN_W]}) + EW'(BIAS_L);
  assign qbit    = (r_q >= {1'b0, d_q});
  assign r_rem   = qbit ? (RW-1)'(r_q - {1'b0, d_q}) : r_q[RW-2:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept start only when idle, iterate NITER cycles, one cycle to finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DIV;
      DIV:     if (cnt_q == CW'(NITER - 1)) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          busy_q <= 1'b1;
          cnt_q  <= '0;
        end
        DIV:  cnt_q <= cnt_q + CW'(1);
        NORM: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= res_d;
          flags_q  <= flg_d;
        end
        default: ;
      endcase
    end
  end

  // Datapath: latch operands on start, then one restoring step per DIV cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      r_q   <= {1'b0, 1'b1, bus.a[MAN_W-1:0]};
      d_q   <= {1'b1, bus.b[MAN_W-1:0]};
      q_q   <= '0;
      e_q   <= e_load;
      s_q   <= bus.a[W-1] ^ bus.b[W-1];
      sel_q <= special ? sel : SP_NONE;
    end else if (state_q == DIV) begin
      r_q <= {r_rem, 1'b0};
      q_q <= {q_q[NITER-2:0], qbit};
    end
  end

  logic                 norm_hi, guard, sticky, carry;
  logic [MAN_W-1:0]     frac, frac_r;
  logic signed [EW-1:0] e_n, e_r;
  logic                 ovf, unf;

  // Normalise the quotient, round, range-check and pick the final result.
  always_comb begin
    norm_hi = q_q[NITER-1];
    if (norm_hi) begin
      frac   = q_q[NITER-2:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|r_q);
      e_n    = e_q;
    end else begin
      frac   = q_q[NITER-3:1];
      guard  = q_q[0];
      sticky = |r_q;
      e_n    = e_q - EW'(1);
    end
    {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(round_inc(guard, sticky, frac[0]));
    e_r = e_n + EW'(carry);
    ovf = !e_r[EW-1] && (e_r >= EMAX);
    unf = e_r[EW-1] || (e_r == '0);

    res_d = '0;
    flg_d = '0;
    case (sel_q)
      SP_NAN: begin
        res_d         = QNAN_W;
        flg_d.invalid = 1'b1;
      end
      SP_INF_DZ: begin
        res_d    = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg_d.dz = 1'b1;
      end
      SP_INF:  res_d = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: res_d = {s_q, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          res_d     = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d.ovf = 1'b1;
        end else if (unf) begin
          res_d     = {s_q, {(W-1){1'b0}}};
          flg_d.unf = 1'b1;
        end else begin
          res_d = {s_q, e_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule
